host_uart_frame_assembler: RTL

//  Upstream stage of the host RX-from-host path. Collects UART bytes from the host into a framed command.

---
 rtl/host_uart_frame_assembler_pkg.sv | 27 ++
 rtl/host_uart_frame_assembler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/host_uart_frame_assembler_pkg.sv
// host_uart_pkg
//   Shared constants and types for the host UART receive path: frame marker,
//   payload limits, inter-byte timeout and the assembler state encoding.
package host_uart_pkg;

  localparam int         MAX_BYTES   = 128;
  localparam int         FRAME_W     = MAX_BYTES * 8;
  localparam logic [7:0] SOF_BYTE    = 8'h7E;
  localparam int         TIMEOUT_CYC = 5000;
  localparam int         TMO_W       = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LEN      = 4'd1,
    ST_PAYLOAD  = 4'd2,
    ST_CHECK    = 4'd3,
    ST_WAIT_RDY = 4'd4,
    ST_ISSUE    = 4'd5,
    ST_BUSY     = 4'd6
  } state_e;

  // A length byte is acceptable when it names at least one and at most MAX_BYTES payload bytes.
  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= 8'(MAX_BYTES));
  endfunction

endpackage

// File: rtl/host_uart_frame_assembler.sv
// host_uart_frame_assembler
//   Collects host UART bytes framed as SOF, LEN, LEN payload bytes, CHK (XOR of the
//   payload), packs the payload MSB-first into a 1024-bit bus, and hands the frame to
//   the command pipeline with a one-cycle send_packet once downstream reports idle.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     rx_byte, rx_valid received byte and its one-cycle strobe
//     down_done         downstream idle (1) / working (0)
//     down_error        downstream error, sampled when down_done rises again
//     frame_data        payload, byte0 at [1023:1016], unused bytes zero
//     frame_len         payload byte count
//     send_packet       one-cycle start strobe
//     busy              frame in progress through downstream completion
//     frame_error       pulse: bad length, bad checksum or inter-byte timeout
//     overrun           pulse: byte dropped while a frame is queued or in flight
//     cmd_error         pulse: downstream completed with down_error set
module host_uart_frame_assembler
  import host_uart_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                down_done,
  input  logic                down_error,
  output logic [FRAME_W-1:0]  frame_data,
  output logic                send_packet,
  output logic [7:0]          frame_len,
  output logic                busy,
  output logic                frame_error,
  output logic                overrun,
  output logic                cmd_error
);

  state_e             state_q, state_d;
  logic [6:0]         idx_q, idx_d;
  logic [7:0]         acc_q, acc_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               seenLow_q, seenLow_d;
  logic [FRAME_W-1:0] frameData_q, frameData_d;
  logic [7:0]         frameLen_q, frameLen_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               frameErr_q, frameErr_d;
  logic               overrun_q, overrun_d;
  logic               cmdErr_q, cmdErr_d;

  logic               inFrame;
  logic               timeoutHit;
  logic               lastByte;
  logic               busyDone;
  logic [9:0]         slotLsb;

  assign inFrame    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  // An arriving byte always beats a simultaneous timeout expiry.
  assign timeoutHit = inFrame && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign lastByte   = ({1'b0, idx_q} == (frameLen_q - 8'd1));
  // Completion needs down_done to have dropped once in BUSY before it rises again.
  assign busyDone   = seenLow_q && down_done;
  assign slotLsb    = 10'(FRAME_W - 8) - {idx_q, 3'b000};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. SOF seen inside a frame is ordinary data; only errors resync.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rx_valid && rx_byte == SOF_BYTE) state_d = ST_LEN;
      ST_LEN: begin
        if (timeoutHit)    state_d = ST_IDLE;
        else if (rx_valid) state_d = len_ok(rx_byte) ? ST_PAYLOAD : ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (timeoutHit)                state_d = ST_IDLE;
        else if (rx_valid && lastByte) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (timeoutHit)    state_d = ST_IDLE;
        else if (rx_valid) state_d = (rx_byte == acc_q) ? ST_WAIT_RDY : ST_IDLE;
      end
      ST_WAIT_RDY: if (down_done) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_BUSY;
      ST_BUSY:     if (busyDone) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; every output is registered below.
  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    frameData_d = frameData_q;
    frameLen_d  = frameLen_q;
    frameErr_d  = timeoutHit;
    overrun_d   = 1'b0;
    cmdErr_d    = 1'b0;
    tmo_d       = '0;
    if (inFrame && !rx_valid && !timeoutHit) tmo_d = tmo_q + 1'b1;
    seenLow_d   = (state_q == ST_BUSY) && (seenLow_q || !down_done) && !busyDone;

    case (state_q)
      ST_LEN: begin
        if (rx_valid) begin
          if (len_ok(rx_byte)) begin
            frameLen_d  = rx_byte;
            frameData_d = '0;
            acc_d       = 8'd0;
            idx_d       = 7'd0;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          frameData_d[slotLsb +: 8] = rx_byte;
          acc_d = acc_q ^ rx_byte;
          idx_d = idx_q + 7'd1;
        end
      end
      ST_CHECK: begin
        if (rx_valid && rx_byte != acc_q) frameErr_d = 1'b1;
      end
      ST_WAIT_RDY, ST_ISSUE: begin
        overrun_d = rx_valid;
      end
      ST_BUSY: begin
        overrun_d = rx_valid;
        if (busyDone) cmdErr_d = down_error;
      end
      default: ;
    endcase

    send_d = (state_d == ST_ISSUE);
    busy_d = (state_d == ST_PAYLOAD) || (state_d == ST_CHECK) || (state_d == ST_WAIT_RDY) ||
             (state_d == ST_ISSUE) || (state_d == ST_BUSY);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      acc_q       <= '0;
      tmo_q       <= '0;
      seenLow_q   <= 1'b0;
      frameData_q <= '0;
      frameLen_q  <= '0;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      cmdErr_q    <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      seenLow_q   <= seenLow_d;
      frameData_q <= frameData_d;
      frameLen_q  <= frameLen_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
      cmdErr_q    <= cmdErr_d;
    end
  end

  assign frame_data  = frameData_q;
  assign frame_len   = frameLen_q;
  assign send_packet = send_q;
  assign busy        = busy_q;
  assign frame_error = frameErr_q;
  assign overrun     = overrun_q;
  assign cmd_error   = cmdErr_q;

endmodule
